jtframe_mc2_inputs: RTL

JTFRAME_MC2_INPUTS -- requirements
Module: jtframe_mc2_inputs

---
 rtl/jtframe_mc2_inputs_if.sv | 13 +
 rtl/jtframe_mc2_inputs.sv | 106 ++++++++++
 2 files changed

// File: rtl/jtframe_mc2_inputs_if.sv
// Board-side joystick bus for jtframe_mc2_inputs: raw active-low board inputs in,
// debounced game-side joystick/start/coin out.
interface jtframe_mc2_inputs_if #(
  parameter int PLAYERS = 2
);
  logic [16*PLAYERS-1:0] board_joy;
  logic [10*PLAYERS-1:0] game_joystick;
  logic [PLAYERS-1:0]    game_start;
  logic [PLAYERS-1:0]    game_coin;

  modport master (output board_joy, input game_joystick, game_start, game_coin);
  modport slave  (input board_joy, output game_joystick, game_start, game_coin);
endinterface

// File: rtl/jtframe_mc2_inputs.sv
// Per-player input conditioning: 2-flop sync, debounce, coin pulse FSM, polarity.
// Define JTFRAME_SOCD_EN to cancel opposing direction pairs (U+D, L+R) after debounce.
module jtframe_mc2_inputs #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 6,
  parameter int DEBOUNCE   = 8,
  parameter int COIN_LEN   = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit MIRROR_P1  = 1'b0
) (
  input logic                 clk_sys,
  input logic                 rst,
  jtframe_mc2_inputs_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} coin_state_t;

  // DEBOUNCE=0 still needs a 1-bit counter; it then sits at 0 and the word follows every sample.
  localparam int DW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int CW = $clog2(COIN_LEN + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [CW-1:0] COIN_MAX = CW'(COIN_LEN);
  localparam logic [5:0]    BTN_MASK = 6'((1 << BUTTONS) - 1);

  // Bits [15:12] of every player, and all non-P0 words when mirroring, are ignored.
  logic [16*PLAYERS-1:0] unused_joy;
  assign unused_joy = bus.board_joy;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    localparam int SRC = MIRROR_P1 ? 0 : p;

    logic [11:0]   raw, sync1, sync2, prev, deb;
    logic [DW-1:0] cnt, cnt_next;
    logic [3:0]    dir_press;
    logic [5:0]    btn_press;
    logic          coin_press;
    coin_state_t   state;
    logic [CW-1:0] coin_cnt;
    logic [9:0]    joy_q;
    logic          start_q, coin_q;

    assign raw = bus.board_joy[16*SRC +: 12];

    always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
      cnt_next = cnt;
      if (sync2 != prev)       cnt_next = '0;
      else if (cnt != DEB_MAX) cnt_next = cnt + 1'b1;

      dir_press = ~deb[3:0];
`ifdef JTFRAME_SOCD_EN
      if (dir_press[0] && dir_press[1]) dir_press[1:0] = 2'b00;
      if (dir_press[2] && dir_press[3]) dir_press[3:2] = 2'b00;
`endif
      btn_press  = ~deb[9:4] & BTN_MASK;
      coin_press = ~deb[11];
    end

    // NOTE: async reset puts the outputs inactive immediately, even mid coin pulse.
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        sync1    <= '1;
        sync2    <= '1;
        prev     <= '1;
        deb      <= '1;
        cnt      <= '0;
        state    <= IDLE;
        coin_cnt <= '0;
        joy_q    <= {10{ACTIVE_LOW}};
        start_q  <= ACTIVE_LOW;
        coin_q   <= ACTIVE_LOW;
      end else begin
        // NOTE: non-blocking assignments so the sync chain shifts one stage per clock.
        sync1 <= raw;
        sync2 <= sync1;
        prev  <= sync2;
        cnt   <= cnt_next;
        if (cnt_next == DEB_MAX) deb <= sync2;

        joy_q   <= {10{ACTIVE_LOW}} ^ {btn_press, dir_press};
        start_q <= ACTIVE_LOW ^ ~deb[10];

        case (state)
          IDLE: if (coin_press) begin
            state    <= PULSE;
            coin_cnt <= CW'(1);
            coin_q   <= ~ACTIVE_LOW;
          end
          PULSE: if (coin_cnt == COIN_MAX) begin
            state  <= WAIT_REL;
            coin_q <= ACTIVE_LOW;
          end else begin
            coin_cnt <= coin_cnt + 1'b1;
          end
          WAIT_REL: if (!coin_press) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end

    assign bus.game_joystick[10*p +: 10] = joy_q;
    assign bus.game_start[p]             = start_q;
    assign bus.game_coin[p]              = coin_q;
  end

endmodule
